// File: rtl/seq_arbiter.sv
// Round-robin arbiter that shares one F/G pulse sequencer among N requesters.
// Grants the sequencer, pulses Start, follows F then G to completion and
// aborts a stalled sequence with a one-cycle sequencer reset.
module seq_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         seq_f_i,
    input  logic         seq_g_i,
    output logic [N-1:0] grant_o,
    output logic         start_o,
    output logic         seq_reset_o,
    output logic [N-1:0] done_o,
    output logic         err_o,
    output logic         busy_o
);

    localparam int unsigned OwnerW = $clog2(N);
    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
    localparam logic [OwnerW-1:0] OwnerLast = OwnerW'(N - 1);
    localparam logic [OwnerW:0]   NWide     = (OwnerW + 1)'(N);
    localparam logic [N-1:0]      OneHot0   = {{(N - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitF,
        StWaitG,
        StDone,
        StAbort
    } state_e;

    state_e              state_q, state_d;
    logic [OwnerW-1:0]   owner_q, owner_d;
    logic [OwnerW-1:0]   ptr_q, ptr_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [N-1:0]        grant_q, grant_d;

    logic [OwnerW-1:0]   winner;
    logic [OwnerW:0]     search_sum;
    logic [OwnerW-1:0]   search_idx;
    logic [OwnerW-1:0]   next_ptr;

    // Winner search: scan downward so the last hit is the first set bit upward from ptr.
    always_comb begin
        winner     = ptr_q;
        search_sum = '0;
        search_idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            search_sum = {1'b0, ptr_q} + (OwnerW + 1)'(i);
            if (search_sum >= NWide) begin
                search_sum = search_sum - NWide;
            end
            search_idx = search_sum[OwnerW-1:0];
            if (req_i[search_idx]) begin
                winner = search_idx;
            end
        end
    end

    // Search start for the next arbitration: one past the requester just served.
    always_comb begin
        next_ptr = (owner_q == OwnerLast) ? '0 : owner_q + OwnerW'(1);
    end

    // Next-state logic for the service FSM, grant, owner, pointer and wait timer.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    owner_d = winner;
                    grant_d = OneHot0 << winner;
                    state_d = StStart;
                end
            end
            StStart: begin
                timer_d = '0;
                state_d = StWaitF;
            end
            StWaitF: begin
                if (seq_f_i) begin
                    timer_d = '0;
                    state_d = StWaitG;
                end else if (timer_q == TimerLast) begin
                    state_d = StAbort;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StWaitG: begin
                if (seq_g_i) begin
                    state_d = StDone;
                end else if (timer_q == TimerLast) begin
                    state_d = StAbort;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StDone, StAbort: begin
                grant_d = '0;
                ptr_d   = next_ptr;
                state_d = StIdle;
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
        end
    end

    // Pulse outputs decoded from the registered state and owner.
    always_comb begin
        grant_o     = grant_q;
        start_o     = (state_q == StStart);
        seq_reset_o = (state_q == StAbort);
        err_o       = (state_q == StAbort);
        done_o      = (state_q == StDone) ? (OneHot0 << owner_q) : '0;
        busy_o      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_seq_arbiter.sv
// Directed bench for seq_arbiter with a behavioural F/G sequencer model and
// a manual override for stalling the sequencer.
module tb_seq_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       seq_f, seq_g;
    logic       manual, man_f, man_g;
    logic       mod_f, mod_g;
    logic [3:0] grant, done;
    logic       start, seq_reset, err, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_arbiter #(
        .N       (4),
        .TIMEOUT (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .seq_f_i     (seq_f),
        .seq_g_i     (seq_g),
        .grant_o     (grant),
        .start_o     (start),
        .seq_reset_o (seq_reset),
        .done_o      (done),
        .err_o       (err),
        .busy_o      (busy)
    );

    // Conforming sequencer: F the cycle after Start, G the cycle after F.
    always @(posedge clk) begin
        if (!rst_n || seq_reset) begin
            mod_f <= 1'b0;
            mod_g <= 1'b0;
        end else begin
            mod_f <= start;
            mod_g <= mod_f;
        end
    end

    assign seq_f = manual ? man_f : mod_f;
    assign seq_g = manual ? man_g : mod_g;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        tick();
        checks++;
        if (grant !== 4'b0000) begin
            errors++; $display("FAIL reset_grant: got %b expected 0000", grant);
        end
        checks++;
        if ({busy, start} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_start: got %b expected 00", {busy, start});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({grant, start} !== 5'b0001_1) begin
            errors++; $display("FAIL reset_first_grant: got %b expected 00011", {grant, start});
        end
        req = 4'b0000;
        tick(); tick(); tick();
        checks++;
        if (done !== 4'b0001) begin
            errors++; $display("FAIL reset_first_done: got %b expected 0001", done);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_first_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        checks++;
        if ({grant, start, done} !== 9'b0100_1_0000) begin
            errors++; $display("FAIL single_start: got %b expected 010010000", {grant, start, done});
        end
        req = 4'b0000;
        for (int c = 2; c <= 3; c++) begin
            tick();
            checks++;
            if ({grant, start, done, busy} !== 10'b0100_0_0000_1) begin
                errors++;
                $display("FAIL single_wait%0d: got %b expected 0100000001", c,
                         {grant, start, done, busy});
            end
        end
        tick();
        checks++;
        if ({grant, done} !== 8'b0100_0100) begin
            errors++; $display("FAIL single_done: got %b expected 01000100", {grant, done});
        end
        tick();
        checks++;
        if ({grant, done, busy} !== 9'b0000_0000_0) begin
            errors++; $display("FAIL single_idle: got %b expected 000000000", {grant, done, busy});
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            exp = 4'b0001 << (k % 4);
            tick();
            checks++;
            if ({grant, start} !== {exp, 1'b1}) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b expected %b", k, {grant, start}, {exp, 1'b1});
            end
            tick(); tick();
            checks++;
            if (done !== 4'b0000) begin
                errors++; $display("FAIL rr_early_done%0d: got %b expected 0000", k, done);
            end
            tick();
            checks++;
            if ({grant, done} !== {exp, exp}) begin
                errors++;
                $display("FAIL rr_done%0d: got %b expected %b", k, {grant, done}, {exp, exp});
            end
            if (k == 19) req = 4'b0000;
            tick();
            checks++;
            if ({busy, start, grant} !== 6'b00_0000) begin
                errors++; $display("FAIL rr_idle%0d: got %b expected 000000", k, {busy, start, grant});
            end
        end
    endtask

    task automatic test_wrap_skip();
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100) begin
            errors++; $display("FAIL wrap_serve2: got %b expected 0100", grant);
        end
        req = 4'b0000;
        tick(); tick(); tick();
        tick();
        req = 4'b0011;
        tick();
        checks++;
        if ({grant, start} !== 5'b0001_1) begin
            errors++; $display("FAIL wrap_grant0: got %b expected 00011", {grant, start});
        end
        tick(); tick(); tick();
        checks++;
        if (done !== 4'b0001) begin
            errors++; $display("FAIL wrap_done0: got %b expected 0001", done);
        end
        tick();
        tick();
        checks++;
        if ({grant, start} !== 5'b0010_1) begin
            errors++; $display("FAIL skip_grant1: got %b expected 00101", {grant, start});
        end
        tick(); tick(); tick();
        checks++;
        if (done !== 4'b0010) begin
            errors++; $display("FAIL skip_done1: got %b expected 0010", done);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        // F stuck low: pointer is 2, so requester 2 wins.
        manual = 1'b1;
        man_f  = 1'b0;
        man_g  = 1'b0;
        req    = 4'b1111;
        tick();
        checks++;
        if ({grant, start} !== 5'b0100_1) begin
            errors++; $display("FAIL tof_start: got %b expected 01001", {grant, start});
        end
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if ({busy, err, seq_reset, done} !== 7'b100_0000) begin
                errors++;
                $display("FAIL tof_wait%0d: got %b expected 1000000", c, {busy, err, seq_reset, done});
            end
        end
        tick();
        checks++;
        if ({seq_reset, err, done, grant} !== 10'b11_0000_0100) begin
            errors++;
            $display("FAIL tof_abort: got %b expected 1100000100", {seq_reset, err, done, grant});
        end
        manual = 1'b0;
        tick();
        checks++;
        if ({busy, err, seq_reset, done, grant} !== 11'b000_0000_0000) begin
            errors++;
            $display("FAIL tof_after: got %b expected 00000000000",
                     {busy, err, seq_reset, done, grant});
        end
        tick();
        checks++;
        if ({grant, start} !== 5'b1000_1) begin
            errors++; $display("FAIL tof_next_grant: got %b expected 10001", {grant, start});
        end
        tick(); tick(); tick();
        checks++;
        if (done !== 4'b1000) begin
            errors++; $display("FAIL tof_next_done: got %b expected 1000", done);
        end
        req = 4'b0000;
        tick();

        // F arrives late, then G stuck low: timer must restart on F.
        manual = 1'b1;
        req    = 4'b0001;
        tick();
        checks++;
        if ({grant, start} !== 5'b0001_1) begin
            errors++; $display("FAIL tog_start: got %b expected 00011", {grant, start});
        end
        req = 4'b0000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            man_f = (c == 4);
            checks++;
            if ({busy, err, seq_reset, done} !== 7'b100_0000) begin
                errors++;
                $display("FAIL tog_wait%0d: got %b expected 1000000", c, {busy, err, seq_reset, done});
            end
        end
        tick();
        checks++;
        if ({seq_reset, err, done} !== 6'b11_0000) begin
            errors++; $display("FAIL tog_abort: got %b expected 110000", {seq_reset, err, done});
        end
        tick();
        checks++;
        if ({busy, err, seq_reset} !== 3'b000) begin
            errors++; $display("FAIL tog_after: got %b expected 000", {busy, err, seq_reset});
        end
        manual = 1'b0;
    endtask

    task automatic test_reset_mid();
        req = 4'b1111;
        tick();
        checks++;
        if ({grant, start} !== 5'b0010_1) begin
            errors++; $display("FAIL mid_start: got %b expected 00101", {grant, start});
        end
        tick();
        tick();
        checks++;
        if ({busy, seq_g, done} !== 6'b11_0000) begin
            errors++; $display("FAIL mid_waitg: got %b expected 110000", {busy, seq_g, done});
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({busy, grant, done, err, start, seq_reset} !== 12'b0_0000_0000_000) begin
            errors++;
            $display("FAIL mid_reset: got %b expected 000000000000",
                     {busy, grant, done, err, start, seq_reset});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({grant, start} !== 5'b0001_1) begin
            errors++; $display("FAIL mid_ptr_zero: got %b expected 00011", {grant, start});
        end
        req = 4'b0000;
        tick(); tick(); tick();
        checks++;
        if (done !== 4'b0001) begin
            errors++; $display("FAIL mid_done: got %b expected 0001", done);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL mid_idle: got %b expected 0", busy);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 4'b0000;
        manual = 1'b0;
        man_f  = 1'b0;
        man_g  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
